injector: RTL

- Stage directly downstream of the ejector in the CHIPPER router pipeline.
- Buffers flits from the local PE in a small FIFO and inserts the head flit into the first empty network channel.
- Computes the injected flit's XY route direction and registers all four channels toward the permutation stage.
- Flags sustained injection starvation so the PE can be throttled.

---
 rtl/router_pkg.sv | 32 +++
 rtl/inj_fifo.sv | 44 ++++
 rtl/injector.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared CHIPPER router definitions: flit field layout, route direction codes and the XY
// route helper used when a PE flit is queued for injection.
package router_pkg;

  localparam int unsigned FLIT_W   = 10;
  localparam int unsigned GOLD_BIT = 9;
  localparam int unsigned DIR_MSB  = 8;
  localparam int unsigned DIR_LSB  = 6;
  localparam int unsigned ADDR_W   = 6;

  localparam logic [2:0] DIR_E = 3'b000;
  localparam logic [2:0] DIR_W = 3'b001;
  localparam logic [2:0] DIR_N = 3'b010;
  localparam logic [2:0] DIR_S = 3'b011;
  localparam logic [2:0] DIR_L = 3'b100;

  // Dimension-ordered: resolve the column first, then the row; local when both match.
  function automatic logic [2:0] xy_route(input logic [ADDR_W-1:0] addr,
                                          input logic [2:0]        row_id,
                                          input logic [2:0]        col_id);
    logic [2:0] row;
    logic [2:0] col;
    row = addr[5:3];
    col = addr[2:0];
    if (col > col_id)      return DIR_E;
    else if (col < col_id) return DIR_W;
    else if (row > row_id) return DIR_N;
    else if (row < row_id) return DIR_S;
    else                   return DIR_L;
  endfunction

endpackage

// File: rtl/inj_fifo.sv
// Synchronous FIFO for PE injection flits; pointers carry an extra wrap bit so full and
// empty are told apart without a separate counter.
module inj_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [Width-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [Width-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(Depth):0]   o_cnt
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [Width-1:0] r_mem [Depth];

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_cnt   = r_wptr - r_rptr;
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push && !o_full) begin
        r_mem[r_wptr[AW-1:0]] <= i_wdata;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (i_pop && !o_empty) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/injector.sv
// CHIPPER injection stage: queues PE flits and drops the head into the first blank channel.
// Optional INJECTOR_STATS_EN adds an inj_count output counting injections.
module injector
  import router_pkg::*;
#(
  parameter int unsigned ROW_ID       = 4,
  parameter int unsigned COL_ID       = 4,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned STARVE_W     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [9:0]                n_in,
  input  logic [9:0]                s_in,
  input  logic [9:0]                e_in,
  input  logic [9:0]                w_in,
  input  logic                      n_in_vld,
  input  logic                      s_in_vld,
  input  logic                      e_in_vld,
  input  logic                      w_in_vld,
  input  logic [9:0]                pe_flit,
  input  logic                      pe_vld,
  output logic                      pe_rdy,
  output logic [9:0]                n_out,
  output logic [9:0]                s_out,
  output logic [9:0]                e_out,
  output logic [9:0]                w_out,
  output logic                      n_out_vld,
  output logic                      s_out_vld,
  output logic                      e_out_vld,
  output logic                      w_out_vld,
  output logic                      starve,
  output logic                      self_drop,
  output logic [$clog2(DEPTH):0]    fifo_cnt
`ifdef INJECTOR_STATS_EN
  ,
  output logic [15:0]               inj_count
`endif
);

  logic                w_full;
  logic                w_empty;
  logic [FLIT_W-1:0]   w_head;
  logic [FLIT_W-1:0]   w_wdata;
  logic                w_pe_fire;
  logic                w_self;
  logic                w_push;
  logic                w_inject;
  logic                w_unused;
  logic [9:0]          w_n;
  logic [9:0]          w_s;
  logic [9:0]          w_e;
  logic [9:0]          w_w;
  logic                w_n_vld;
  logic                w_s_vld;
  logic                w_e_vld;
  logic                w_w_vld;
  logic [STARVE_W-1:0] w_starve_cnt_d;
  logic [STARVE_W-1:0] r_starve_cnt;

  assign w_unused  = ^pe_flit[9:6];
  assign pe_rdy    = !w_full;
  assign w_pe_fire = pe_vld && pe_rdy;
  assign w_self    = (pe_flit[5:0] == {3'(ROW_ID), 3'(COL_ID)});
  assign w_push    = w_pe_fire && !w_self;
  assign w_wdata   = {1'b0, xy_route(pe_flit[5:0], 3'(ROW_ID), 3'(COL_ID)), pe_flit[5:0]};

  inj_fifo #(
    .Width (FLIT_W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_inject),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_cnt   (fifo_cnt)
  );

  // Blank slots are zeroed; the head takes the first blank in N, S, E, W order.
  always_comb begin
    w_n      = n_in_vld ? n_in : '0;
    w_s      = s_in_vld ? s_in : '0;
    w_e      = e_in_vld ? e_in : '0;
    w_w      = w_in_vld ? w_in : '0;
    w_n_vld  = n_in_vld;
    w_s_vld  = s_in_vld;
    w_e_vld  = e_in_vld;
    w_w_vld  = w_in_vld;
    w_inject = 1'b0;
    if (!w_empty) begin
      if (!n_in_vld) begin
        w_n      = w_head;
        w_n_vld  = 1'b1;
        w_inject = 1'b1;
      end else if (!s_in_vld) begin
        w_s      = w_head;
        w_s_vld  = 1'b1;
        w_inject = 1'b1;
      end else if (!e_in_vld) begin
        w_e      = w_head;
        w_e_vld  = 1'b1;
        w_inject = 1'b1;
      end else if (!w_in_vld) begin
        w_w      = w_head;
        w_w_vld  = 1'b1;
        w_inject = 1'b1;
      end
    end
  end

  // A non-empty FIFO that did not inject means every channel was occupied.
  always_comb begin
    w_starve_cnt_d = r_starve_cnt;
    if (w_empty || w_inject) begin
      w_starve_cnt_d = '0;
    end else if (r_starve_cnt != '1) begin
      w_starve_cnt_d = r_starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_out        <= '0;
      s_out        <= '0;
      e_out        <= '0;
      w_out        <= '0;
      n_out_vld    <= 1'b0;
      s_out_vld    <= 1'b0;
      e_out_vld    <= 1'b0;
      w_out_vld    <= 1'b0;
      r_starve_cnt <= '0;
      starve       <= 1'b0;
      self_drop    <= 1'b0;
    end else begin
      n_out        <= w_n;
      s_out        <= w_s;
      e_out        <= w_e;
      w_out        <= w_w;
      n_out_vld    <= w_n_vld;
      s_out_vld    <= w_s_vld;
      e_out_vld    <= w_e_vld;
      w_out_vld    <= w_w_vld;
      r_starve_cnt <= w_starve_cnt_d;
      starve       <= (r_starve_cnt >= STARVE_W'(STARVE_LIMIT));
      self_drop    <= w_pe_fire && w_self;
    end
  end

`ifdef INJECTOR_STATS_EN
  logic [15:0] r_inj_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inj_count <= '0;
    end else if (w_inject) begin
      r_inj_count <= r_inj_count + 16'd1;
    end
  end

  assign inj_count = r_inj_count;
`endif

endmodule
